// File: rtl/hfrv_trace_buffer.sv
// hfrv_trace_buffer
// -----------------------------------------------------------------------------
// Purpose:
//   On-chip retire-trace capture buffer for the HF-RISC debug flow. It records
//   retired-instruction events ({pc, instruction, sequence number}) into a small
//   circular buffer. The buffer is drained oldest-first over a
//   first-word-fall-through valid/ready port. Three capture modes are supported:
//     WRAP (0) : keep the newest DEPTH events and overwrite the oldest.
//     STOP (1) : keep the first DEPTH events and discard the rest.
//     TRIG (2) : wrap until ev_pc matches trig_addr, record post_count more
//                events, then freeze.
//     3        : reserved, behaves as STOP.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   arm                   pulse: clear the buffer, latch the config, start capture
//   mode, trig_addr,      capture configuration, sampled on arm
//   post_count
//   ev_valid, ev_pc,      retire event from the core
//   ev_instr
//   rd_valid, rd_ready    drain handshake (pop on rd_valid && rd_ready)
//   rd_pc, rd_instr,      head entry, forced to 0 while the buffer is empty
//   rd_seq
//   count                 number of valid entries
//   capturing             high in CAPTURE or POST
//   triggered             trigger has matched in the current run
//   dropped               events lost or overwritten, saturating
// -----------------------------------------------------------------------------
module hfrv_trace_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int SEQ_W = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arm,
    input  logic [1:0]       mode,
    input  logic [XLEN-1:0]  trig_addr,
    input  logic [AW:0]      post_count,
    input  logic             ev_valid,
    input  logic [XLEN-1:0]  ev_pc,
    input  logic [31:0]      ev_instr,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [XLEN-1:0]  rd_pc,
    output logic [31:0]      rd_instr,
    output logic [SEQ_W-1:0] rd_seq,
    output logic [AW:0]      count,
    output logic             capturing,
    output logic             triggered,
    output logic [SEQ_W-1:0] dropped
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_POST    = 2'd2;
    localparam logic [1:0] S_FROZEN  = 2'd3;

    localparam logic [1:0] MODE_WRAP = 2'd0;
    localparam logic [1:0] MODE_TRIG = 2'd2;

    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0] ONE_CNT  = {{AW{1'b0}}, 1'b1};

    logic [1:0]       state;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic [AW:0]      remaining;
    logic [SEQ_W-1:0] seq;
    logic [SEQ_W-1:0] drop_cnt;
    logic             trig_seen;
    logic [1:0]       mode_q;
    logic [XLEN-1:0]  trig_q;
    logic [AW:0]      post_q;

    logic [XLEN-1:0]  pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];
    logic [SEQ_W-1:0] seq_mem   [DEPTH];

    logic active;
    logic accept;
    logic is_empty;
    logic is_full;
    logic do_pop;
    logic wrap_mode;
    logic do_write;
    logic overwrite;
    logic do_drop;
    logic trig_match;

    // Event classification. A pop in the same cycle frees a slot before the
    // push, so a full buffer with a concurrent pop neither overwrites nor drops.
    // Mode 3 is not a wrap mode, so it falls through to STOP behaviour.
    always_comb begin
        active     = (state == S_CAPTURE) || (state == S_POST);
        accept     = ev_valid && active;
        is_empty   = (cnt == '0);
        is_full    = (cnt == FULL_CNT);
        do_pop     = !is_empty && rd_ready;
        wrap_mode  = (mode_q == MODE_WRAP) || (mode_q == MODE_TRIG);
        do_write   = accept && (!is_full || do_pop || wrap_mode);
        overwrite  = accept && is_full && !do_pop && wrap_mode;
        do_drop    = accept && is_full && !do_pop;
        trig_match = accept && (state == S_CAPTURE) && (mode_q == MODE_TRIG) &&
                     !trig_seen && (ev_pc == trig_q);
    end

    // Control state, pointers and counters. Reset beats arm, and arm beats
    // any event or pop in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            remaining <= '0;
            seq       <= '0;
            drop_cnt  <= '0;
            trig_seen <= 1'b0;
            mode_q    <= '0;
            trig_q    <= '0;
            post_q    <= '0;
        end else if (arm) begin
            state     <= S_CAPTURE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            remaining <= '0;
            seq       <= '0;
            drop_cnt  <= '0;
            trig_seen <= 1'b0;
            mode_q    <= mode;
            trig_q    <= trig_addr;
            post_q    <= post_count;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            // An overwrite evicts the oldest entry, so the head moves too.
            if (do_pop || overwrite) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_write && !do_pop && !overwrite) begin
                cnt <= cnt + 1'b1;
            end else if (!do_write && do_pop) begin
                cnt <= cnt - 1'b1;
            end
            // Sequence numbers advance even for dropped events so gaps show up.
            if (accept) begin
                seq <= seq + 1'b1;
            end
            if (do_drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            if (trig_match) begin
                trig_seen <= 1'b1;
                if (post_q == '0) begin
                    state <= S_FROZEN;
                end else begin
                    state     <= S_POST;
                    remaining <= post_q;
                end
            end else if ((state == S_POST) && accept) begin
                remaining <= remaining - 1'b1;
                if (remaining == ONE_CNT) begin
                    state <= S_FROZEN;
                end
            end
        end
    end

    // Entry storage; no reset needed because empty entries are never shown.
    always_ff @(posedge clk) begin
        if (!reset && !arm && do_write) begin
            pc_mem[wr_ptr]    <= ev_pc;
            instr_mem[wr_ptr] <= ev_instr;
            seq_mem[wr_ptr]   <= seq;
        end
    end

    always_comb begin
        rd_valid  = !is_empty;
        rd_pc     = is_empty ? '0 : pc_mem[rd_ptr];
        rd_instr  = is_empty ? '0 : instr_mem[rd_ptr];
        rd_seq    = is_empty ? '0 : seq_mem[rd_ptr];
        count     = cnt;
        capturing = active;
        triggered = trig_seen;
        dropped   = drop_cnt;
    end

endmodule

// File: tb/tb_hfrv_trace_buffer.sv
// tb_hfrv_trace_buffer
// -----------------------------------------------------------------------------
// Self-checking bench for hfrv_trace_buffer. A queue-based reference model
// tracks the buffer contents. Entries the model pops are pushed into a
// scoreboard queue, and a negedge monitor compares them against what the DUT
// presents when it pops.
// -----------------------------------------------------------------------------
module tb_hfrv_trace_buffer;

    localparam int DEPTH = 16;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [15:0] seq;
    } ent_t;

    logic        clk;
    logic        reset;
    logic        arm;
    logic [1:0]  mode;
    logic [31:0] trig_addr;
    logic [4:0]  post_count;
    logic        ev_valid;
    logic [31:0] ev_pc;
    logic [31:0] ev_instr;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_pc;
    logic [31:0] rd_instr;
    logic [15:0] rd_seq;
    logic [4:0]  count;
    logic        capturing;
    logic        triggered;
    logic [15:0] dropped;

    int total = 0;
    int bad   = 0;

    // Reference model: the buffer is just a queue of entries.
    ent_t        mq[$];
    ent_t        expq[$];
    int          m_phase;   // 0 idle, 1 capture, 2 post, 3 frozen
    int          m_mode;
    int          m_post;
    int          m_left;
    logic [31:0] m_trig;
    int          m_seq;
    int          m_drop;
    bit          m_trigd;

    // Model view of the DUT outputs during the current cycle.
    int cur_count = 0;
    int cur_drop  = 0;
    bit cur_trig  = 0;
    bit cur_capt  = 0;
    bit mon_en    = 0;

    hfrv_trace_buffer #(.XLEN(32), .DEPTH(DEPTH), .SEQ_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .arm        (arm),
        .mode       (mode),
        .trig_addr  (trig_addr),
        .post_count (post_count),
        .ev_valid   (ev_valid),
        .ev_pc      (ev_pc),
        .ev_instr   (ev_instr),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_pc      (rd_pc),
        .rd_instr   (rd_instr),
        .rd_seq     (rd_seq),
        .count      (count),
        .capturing  (capturing),
        .triggered  (triggered),
        .dropped    (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelStep(input bit r, input bit a, input int m, input logic [31:0] ta,
                             input int pcnt, input bit ev, input logic [31:0] pc,
                             input logic [31:0] ins, input bit rdy);
        ent_t e;
        if (r) begin
            mq.delete();
            m_phase = 0; m_seq = 0; m_drop = 0; m_trigd = 0; m_left = 0;
        end else if (a) begin
            mq.delete();
            m_phase = 1; m_seq = 0; m_drop = 0; m_trigd = 0;
            m_mode = m; m_trig = ta; m_post = pcnt;
        end else begin
            if (rdy && mq.size() > 0) begin
                expq.push_back(mq[0]);
                void'(mq.pop_front());
            end
            if (ev && (m_phase == 1 || m_phase == 2)) begin
                e.pc = pc; e.instr = ins; e.seq = m_seq[15:0];
                if (mq.size() < DEPTH) begin
                    mq.push_back(e);
                end else begin
                    if (m_mode == 0 || m_mode == 2) begin
                        void'(mq.pop_front());
                        mq.push_back(e);
                    end
                    if (m_drop < 65535) m_drop++;
                end
                m_seq = (m_seq + 1) % 65536;
                if (m_phase == 1 && m_mode == 2 && !m_trigd && pc == m_trig) begin
                    m_trigd = 1;
                    if (m_post == 0) m_phase = 3;
                    else begin
                        m_phase = 2;
                        m_left  = m_post;
                    end
                end else if (m_phase == 2) begin
                    m_left--;
                    if (m_left == 0) m_phase = 3;
                end
            end
        end
    endtask

    // Drives one cycle of inputs just after the rising edge and advances the
    // model. On return the DUT reflects every earlier call.
    task automatic applyStimulus(input bit r, input bit a, input int m, input logic [31:0] ta,
                                 input int pcnt, input bit ev, input logic [31:0] pc,
                                 input bit rdy);
        logic [31:0] ins;
        @(posedge clk);
        #1;
        cur_count = mq.size();
        cur_drop  = m_drop;
        cur_trig  = m_trigd;
        cur_capt  = (m_phase == 1 || m_phase == 2);
        mon_en    = 1;
        ins        = $urandom;
        reset      = r;
        arm        = a;
        mode       = m[1:0];
        trig_addr  = ta;
        post_count = pcnt[4:0];
        ev_valid   = ev;
        ev_pc      = pc;
        ev_instr   = ins;
        rd_ready   = rdy;
        modelStep(r, a, m, ta, pcnt, ev, pc, ins, rdy);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, rdy);
    endtask

    task automatic events(input int n, input bit rdy);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 1, 32'h100 + 4 * i, rdy);
    endtask

    // Monitor: status against the model every cycle, popped entries against
    // the scoreboard queue.
    always @(negedge clk) begin
        if (mon_en) begin
            ent_t e;
            checkOutput("count", count, cur_count);
            checkOutput("rd_valid", rd_valid, cur_count != 0);
            checkOutput("dropped", dropped, cur_drop);
            checkOutput("triggered", triggered, cur_trig);
            checkOutput("capturing", capturing, cur_capt);
            if (cur_count == 0) begin
                checkOutput("empty_rd_pc", rd_pc, 0);
                checkOutput("empty_rd_seq", rd_seq, 0);
                checkOutput("empty_rd_instr", rd_instr, 0);
            end
            if (rd_valid && rd_ready && !arm && !reset) begin
                if (expq.size() == 0) begin
                    checkOutput("unexpected_pop", 1, 0);
                end else begin
                    e = expq.pop_front();
                    checkOutput("pop_pc", rd_pc, e.pc);
                    checkOutput("pop_instr", rd_instr, e.instr);
                    checkOutput("pop_seq", rd_seq, e.seq);
                end
            end
        end
    end

    initial begin
        reset = 1; arm = 0; mode = 0; trig_addr = 0; post_count = 0;
        ev_valid = 0; ev_pc = 0; ev_instr = 0; rd_ready = 0;
        m_phase = 0; m_mode = 0; m_post = 0; m_left = 0; m_trig = 0;
        m_seq = 0; m_drop = 0; m_trigd = 0;
        repeat (3) @(posedge clk);

        // No arm: events are ignored.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        events(5, 0);
        idle(1, 0);
        checkOutput("noarm_count", count, 0);
        checkOutput("noarm_capturing", capturing, 0);

        // STOP: first 16 kept, 4 dropped.
        applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
        events(20, 0);
        idle(1, 0);
        checkOutput("stop_count", count, 16);
        checkOutput("stop_dropped", dropped, 4);
        checkOutput("stop_head_pc", rd_pc, 32'h100);
        idle(17, 1);

        // WRAP: newest 16 kept, head is event 4.
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        events(20, 0);
        idle(1, 0);
        checkOutput("wrap_count", count, 16);
        checkOutput("wrap_dropped", dropped, 4);
        checkOutput("wrap_head_pc", rd_pc, 32'h110);
        checkOutput("wrap_head_seq", rd_seq, 4);
        idle(17, 1);

        // TRIG at 0x120 with 3 post events: frozen after event 11.
        applyStimulus(0, 1, 2, 32'h120, 3, 0, 0, 0);
        events(20, 0);
        idle(1, 0);
        checkOutput("trig_count", count, 12);
        checkOutput("trig_capturing", capturing, 0);
        checkOutput("trig_triggered", triggered, 1);
        idle(13, 1);

        // WRAP full with a simultaneous push and pop.
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        events(16, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h140, 1);
        idle(1, 0);
        checkOutput("pushpop_count", count, 16);
        checkOutput("pushpop_dropped", dropped, 0);
        checkOutput("pushpop_head_seq", rd_seq, 1);
        idle(17, 1);

        // Reset while in POST.
        applyStimulus(0, 1, 2, 32'h108, 5, 0, 0, 0);
        events(4, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        idle(1, 0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_triggered", triggered, 0);
        checkOutput("rst_dropped", dropped, 0);
        checkOutput("rst_capturing", capturing, 0);

        // Re-arm with 7 entries held; the event alongside arm is discarded.
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        events(7, 0);
        applyStimulus(0, 1, 0, 0, 0, 1, 32'h200, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h204, 0);
        idle(1, 0);
        checkOutput("rearm_count", count, 1);
        checkOutput("rearm_seq", rd_seq, 0);
        checkOutput("rearm_pc", rd_pc, 32'h204);

        // Randomised traffic with occasional arm and reset.
        for (int c = 0; c < 3000; c++) begin
            bit          r;
            bit          a;
            bit          ev;
            bit          rdy;
            logic [31:0] pc;
            logic [31:0] ta;
            r   = ($urandom_range(0, 499) == 0);
            a   = (c == 0) || ($urandom_range(0, 99) == 0);
            ev  = ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 9) < 4);
            pc  = 32'h100 + 4 * $urandom_range(0, 31);
            ta  = 32'h100 + 4 * $urandom_range(0, 31);
            applyStimulus(r, a, $urandom_range(0, 3), ta, $urandom_range(0, 16), ev, pc, rdy);
        end

        idle(20, 1);
        @(negedge clk);
        #1;
        mon_en = 0;
        checkOutput("scoreboard_left", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hfrv_trace_buffer.md
Name: hfrv_trace_buffer

Overview:
- Parametrised on-chip retire-trace capture buffer for the HF-RISC verification and debug flow.
- Records retired-instruction events (PC, instruction word, sequence number) from the core's retire port.
- Supports three capture modes: wrap, stop-when-full and trigger-plus-post-count.
- Drains oldest-first over a valid/ready port, so the bench or a debug UART bridge can read execution history without a simulation-only monitor.

Parameters:
- XLEN, 32, width of the PC and trigger address.
- DEPTH, 16, number of entries; must be a power of 2 and at least 2. Define AW = log2(DEPTH).
- SEQ_W, 16, width of the event sequence counter and of the dropped-event counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- arm  in  1  single-cycle pulse: clear the buffer and start capture.
- mode  in  2  capture mode, sampled at arm: 0 WRAP, 1 STOP, 2 TRIG, 3 reserved (behaves as STOP).
- trig_addr  in  XLEN  trigger PC, sampled at arm.
- post_count  in  AW+1  number of events to record after the trigger event, sampled at arm.
- ev_valid  in  1  a retire event is present this cycle.
- ev_pc  in  XLEN  PC of the retired instruction.
- ev_instr  in  32  retired instruction word.
- rd_valid  out  1  high when the buffer holds at least one entry.
- rd_ready  in  1  consumer accepts the head entry.
- rd_pc  out  XLEN  head entry PC.
- rd_instr  out  32  head entry instruction word.
- rd_seq  out  SEQ_W  head entry sequence number.
- count  out  AW+1  number of valid entries.
- capturing  out  1  high in the CAPTURE or POST state.
- triggered  out  1  high once the trigger has matched in the current run.
- dropped  out  SEQ_W  number of events lost or overwritten; saturates at all-ones.

Behaviour:
- Reset:
  - State goes to IDLE; write pointer, read pointer, count, seq, dropped, triggered and the remaining-post counter are all set to 0.
  - Every output reads 0 (rd_valid, count, capturing, triggered, dropped, and the rd_* fields, which are forced to 0 while the buffer is empty).
  - Reset overrides arm.
- States: IDLE, CAPTURE, POST, FROZEN.
  - IDLE and FROZEN ignore ev_valid; seq does not increment in these states.
  - Draining is allowed in every state.
- Arm:
  - In any state, arm moves the block to CAPTURE on the next cycle.
  - It clears the pointers, count, seq, dropped and triggered, and latches mode, trig_addr and post_count.
  - arm has priority over an event or pop in the same cycle; both are discarded.
- Capture:
  - Each ev_valid in CAPTURE or POST writes {ev_pc, ev_instr, seq} at the write pointer, unless the full rules below say otherwise.
  - seq increments (and wraps) on every ev_valid seen in CAPTURE or POST, including dropped events, so gaps are visible.
- Full in WRAP mode and TRIG mode:
  - The new entry overwrites the oldest one, the read pointer advances, count stays at DEPTH, and dropped is incremented.
- Full in STOP mode:
  - The event is discarded and dropped is incremented. The state stays CAPTURE.
- Trigger (TRIG mode):
  - In CAPTURE, an event with ev_valid and ev_pc == trig_addr is written normally and sets triggered = 1.
  - If post_count == 0, the next state is FROZEN. Otherwise the next state is POST with remaining = post_count.
  - In POST, each ev_valid is written, remaining decrements, and the state goes to FROZEN on the cycle the counter reaches 0.
  - Only the first match counts; later matches have no further effect.
- Read:
  - The port is first-word-fall-through: rd_* reflect the entry at the read pointer combinationally from the register array.
  - A pop happens when rd_valid && rd_ready. Popping with count == 0 has no effect.
- Simultaneous push and pop:
  - The pop is applied first, so count is unchanged.
  - A push while full plus a pop in the same cycle does not overwrite and does not increment dropped, in any mode.
- Pointers are AW bits wide and wrap naturally. count is the only full/empty indicator.
- capturing = (state == CAPTURE || state == POST), driven from registered state.
- dropped saturates at 2^SEQ_W − 1.

Test Plan:
Defaults for all scenarios: DEPTH = 16, events on consecutive cycles with ev_pc = 0x100 + 4i.
1. Reset, no arm, 5 events -> count = 0, rd_valid = 0, seq unchanged, capturing = 0.
2. arm with mode = 1 (STOP), events i = 0..19, then drain -> count = 16, dropped = 4; reads return pc 0x100..0x13C with seq 0..15.
3. arm with mode = 0 (WRAP), events i = 0..19 -> count = 16, dropped = 4; first read is pc 0x110, seq 4; last read is pc 0x14C, seq 19.
4. arm with mode = 2 (TRIG), trig_addr = 0x120, post_count = 3, events i = 0..19 -> triggered = 1 at i = 8, FROZEN after i = 11, count = 12, capturing = 0; last read is pc 0x12C; events i = 12..19 are ignored.
5. WRAP mode, buffer full, ev_valid and a pop in the same cycle -> count stays 16, dropped is unchanged, the popped head advances by one seq.
6. reset asserted in POST -> next cycle IDLE, count = 0, triggered = 0, dropped = 0. arm asserted during CAPTURE with 7 entries -> count = 0, and the next event is stored with seq 0.
